// File: rtl/msg_rx_depacketizer.sv
// Receive-side message depacketizer: filters messages by RX_UID, strips the
// header word and forwards the payload through a one-deep output register.
// Overlength payloads are cut at MAX_WORDS and status counters saturate.
module msg_rx_depacketizer #(
    parameter logic [7:0]  LOCAL_UID = 8'h02,
    parameter logic [7:0]  BCAST_UID = 8'hFF,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk_200MHz,
    input  logic        peripheral_reset,
    input  logic [31:0] s_TDATA,
    input  logic        s_TLAST,
    input  logic        s_TVALID,
    output logic        s_TREADY,
    output logic [31:0] m_TDATA,
    output logic        m_TLAST,
    output logic        m_TVALID,
    input  logic        m_TREADY,
    output logic [7:0]  m_tx_uid,
    output logic [15:0] msg_ok_cnt,
    output logic [15:0] msg_drop_cnt,
    output logic [15:0] msg_err_cnt,
    output logic        busy
);

    localparam logic [1:0] ST_HDR  = 2'd0;
    localparam logic [1:0] ST_PASS = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    // Index of the last payload word that may be forwarded in one message.
    localparam logic [15:0] LAST_IDX = 16'(MAX_WORDS - 1);

    logic [1:0]  state;
    logic [15:0] word_cnt;
    logic        out_free;
    logic        in_xfer;
    logic        hdr_match;
    logic        at_limit;
    logic        ok_inc;
    logic        drop_inc;
    logic        err_inc;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign out_free  = !m_TVALID || m_TREADY;
    assign in_xfer   = s_TVALID && s_TREADY;
    assign hdr_match = (s_TDATA[31:24] == LOCAL_UID) || (s_TDATA[31:24] == BCAST_UID);
    assign at_limit  = (word_cnt == LAST_IDX);
    assign busy      = (state != ST_HDR) || m_TVALID;

    // Input ready: headers wait for a pending word so m_tx_uid cannot change under it.
    always_comb begin
        s_TREADY = 1'b0;
        if (!peripheral_reset) begin
            case (state)
                ST_HDR:  s_TREADY = out_free;
                ST_PASS: s_TREADY = out_free;
                ST_DROP: s_TREADY = 1'b1;
                default: s_TREADY = 1'b0;
            endcase
        end
    end

    // Counter increment events; ok and err can fire together on truncation.
    always_comb begin
        ok_inc   = 1'b0;
        drop_inc = 1'b0;
        err_inc  = 1'b0;
        if (in_xfer) begin
            if (state == ST_HDR) begin
                err_inc  = s_TLAST;
                drop_inc = !s_TLAST && !hdr_match;
            end else if (state == ST_PASS) begin
                ok_inc  = s_TLAST || at_limit;
                err_inc = !s_TLAST && at_limit;
            end
        end
    end

    // Message FSM, payload word counter and latched TX_UID.
    always_ff @(posedge clk_200MHz) begin
        if (peripheral_reset) begin
            state    <= ST_HDR;
            word_cnt <= 16'd0;
            m_tx_uid <= 8'd0;
        end else if (in_xfer) begin
            case (state)
                ST_HDR: begin
                    if (!s_TLAST) begin
                        if (hdr_match) begin
                            m_tx_uid <= s_TDATA[23:16];
                            word_cnt <= 16'd0;
                            state    <= ST_PASS;
                        end else begin
                            state <= ST_DROP;
                        end
                    end
                end
                ST_PASS: begin
                    word_cnt <= word_cnt + 16'd1;
                    if (s_TLAST) begin
                        state <= ST_HDR;
                    end else if (at_limit) begin
                        state <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (s_TLAST) begin
                        state <= ST_HDR;
                    end
                end
                default: state <= ST_HDR;
            endcase
        end
    end

    // One-deep output register; holds data stable until the consumer takes it.
    always_ff @(posedge clk_200MHz) begin
        if (peripheral_reset) begin
            m_TVALID <= 1'b0;
            m_TLAST  <= 1'b0;
            m_TDATA  <= 32'd0;
        end else if (in_xfer && (state == ST_PASS)) begin
            m_TVALID <= 1'b1;
            m_TDATA  <= s_TDATA;
            m_TLAST  <= s_TLAST || at_limit;
        end else if (m_TREADY) begin
            m_TVALID <= 1'b0;
        end
    end

    // Saturating status counters.
    always_ff @(posedge clk_200MHz) begin
        if (peripheral_reset) begin
            msg_ok_cnt   <= 16'd0;
            msg_drop_cnt <= 16'd0;
            msg_err_cnt  <= 16'd0;
        end else begin
            if (ok_inc)   msg_ok_cnt   <= sat_inc(msg_ok_cnt);
            if (drop_inc) msg_drop_cnt <= sat_inc(msg_drop_cnt);
            if (err_inc)  msg_err_cnt  <= sat_inc(msg_err_cnt);
        end
    end

endmodule

// File: tb/tb_msg_rx_depacketizer.sv
// Self-checking bench for msg_rx_depacketizer: message-level reference model,
// randomized and directed messages, per-cycle output and handshake checks.
module tb_msg_rx_depacketizer;

    localparam logic [7:0] LOCAL = 8'h02;
    localparam logic [7:0] BCAST = 8'hFF;
    localparam int         MAXW  = 256;

    localparam int TAG_HDR  = 0;
    localparam int TAG_PASS = 1;
    localparam int TAG_DROP = 2;

    logic        clk_200MHz = 1'b0;
    logic        peripheral_reset = 1'b1;
    logic [31:0] s_TDATA = 32'd0;
    logic        s_TLAST = 1'b0;
    logic        s_TVALID = 1'b0;
    logic        s_TREADY;
    logic [31:0] m_TDATA;
    logic        m_TLAST;
    logic        m_TVALID;
    logic        m_TREADY = 1'b1;
    logic [7:0]  m_tx_uid;
    logic [15:0] msg_ok_cnt;
    logic [15:0] msg_drop_cnt;
    logic [15:0] msg_err_cnt;
    logic        busy;

    msg_rx_depacketizer #(
        .LOCAL_UID(LOCAL),
        .BCAST_UID(BCAST),
        .MAX_WORDS(MAXW)
    ) dut (
        .clk_200MHz      (clk_200MHz),
        .peripheral_reset(peripheral_reset),
        .s_TDATA         (s_TDATA),
        .s_TLAST         (s_TLAST),
        .s_TVALID        (s_TVALID),
        .s_TREADY        (s_TREADY),
        .m_TDATA         (m_TDATA),
        .m_TLAST         (m_TLAST),
        .m_TVALID        (m_TVALID),
        .m_TREADY        (m_TREADY),
        .m_tx_uid        (m_tx_uid),
        .msg_ok_cnt      (msg_ok_cnt),
        .msg_drop_cnt    (msg_drop_cnt),
        .msg_err_cnt     (msg_err_cnt),
        .busy            (busy)
    );

    always #5 clk_200MHz = ~clk_200MHz;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic [7:0]  u;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   m_ok = 0, m_drop = 0, m_err = 0;
    int   out_words = 0;
    int   cur_tag = TAG_HDR;
    int   rmode = 0;
    bit   gaps = 0;
    bit   lat_chk = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Consumer ready pattern: always, alternating, or random.
    initial begin
        forever begin
            @(posedge clk_200MHz);
            #1;
            case (rmode)
                0: m_TREADY = 1'b1;
                1: m_TREADY = !m_TREADY;
                default: m_TREADY = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Compare process: handshake rule, hold stability and output stream contents.
    logic        hold = 0;
    logic [31:0] hold_d;
    logic        hold_l;
    always @(negedge clk_200MHz) begin
        exp_t e;
        if (peripheral_reset) begin
            hold = 0;
        end else begin
            if (s_TVALID)
                check("s_TREADY_rule", s_TREADY,
                      (cur_tag == TAG_DROP) ? 1'b1 : (!m_TVALID || m_TREADY));
            if (hold) begin
                check("hold_valid", m_TVALID, 1'b1);
                check("hold_data", m_TDATA, hold_d);
                check("hold_last", m_TLAST, hold_l);
            end
            hold   = m_TVALID && !m_TREADY;
            hold_d = m_TDATA;
            hold_l = m_TLAST;
            if (m_TVALID && m_TREADY) begin
                if (expq.size() == 0) begin
                    check("unexpected_output", m_TDATA, 32'hDEAD_BEEF);
                end else begin
                    e = expq.pop_front();
                    check("out_data", m_TDATA, e.d);
                    check("out_last", m_TLAST, e.l);
                    check("out_tx_uid", m_tx_uid, e.u);
                    out_words++;
                end
            end
        end
    end

    // Present one word on the input and wait for it to be taken (bounded).
    task automatic drive_word(input logic [31:0] d, input logic l, input int tag);
        bit hs;
        int n;
        cur_tag = tag;
        s_TDATA = d;
        s_TLAST = l;
        while (gaps && ($urandom_range(0, 3) == 0)) begin
            s_TVALID = 1'b0;
            @(posedge clk_200MHz);
            #1;
        end
        s_TVALID = 1'b1;
        n = 0;
        forever begin
            @(negedge clk_200MHz);
            hs = s_TREADY;
            @(posedge clk_200MHz);
            #1;
            if (hs) break;
            n++;
            if (n > 2000) begin
                $display("FAIL input_timeout: got stalled expected accept");
                n_fail++;
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $fatal(1, "input stalled");
            end
        end
        s_TVALID = 1'b0;
    endtask

    // Send one message; the model derives expected output from message-level rules.
    // abort_k >= 0 sends only that many payload words (message left unfinished).
    task automatic send_msg(input logic [31:0] hdr, input int n, input bit ones, input int abort_k);
        logic [31:0] pl[$];
        bit   acc;
        int   full_fwd, nsend;
        exp_t e;
        acc = ((hdr[31:24] == LOCAL) || (hdr[31:24] == BCAST)) && (n > 0);
        for (int i = 0; i < n; i++) pl.push_back(ones ? 32'd1 : $urandom);
        nsend    = (abort_k >= 0) ? abort_k : n;
        full_fwd = (n < MAXW) ? n : MAXW;
        if (acc) begin
            for (int i = 0; i < full_fwd && i < nsend; i++) begin
                e.d = pl[i];
                e.l = (i == full_fwd - 1);
                e.u = hdr[23:16];
                expq.push_back(e);
            end
        end
        if (abort_k < 0) begin
            if (n == 0) m_err = sat(m_err);
            else if (acc) begin
                m_ok = sat(m_ok);
                if (n > MAXW) m_err = sat(m_err);
            end else m_drop = sat(m_drop);
        end
        drive_word(hdr, (n == 0), TAG_HDR);
        if (lat_chk) check("hdr_emits_nothing", m_TVALID, 1'b0);
        for (int i = 0; i < nsend; i++) begin
            drive_word(pl[i], (i == n - 1), (acc && i < MAXW) ? TAG_PASS : TAG_DROP);
            if (lat_chk && i == 0) begin
                check("first_out_latency", m_TVALID, 1'b1);
                check("first_out_data", m_TDATA, pl[0]);
                lat_chk = 0;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge clk_200MHz);
            if (!busy && expq.size() == 0) break;
            n++;
            if (n > 5000) begin
                check("idle_timeout", busy, 1'b0);
                break;
            end
        end
        @(posedge clk_200MHz);
        #1;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_ok_cnt"}, msg_ok_cnt, m_ok);
        check({tag, "_drop_cnt"}, msg_drop_cnt, m_drop);
        check({tag, "_err_cnt"}, msg_err_cnt, m_err);
        check({tag, "_pending"}, expq.size(), 0);
    endtask

    task automatic do_reset(input int cyc);
        peripheral_reset = 1'b1;
        s_TVALID = 1'b0;
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk_200MHz);
            check("rst_s_TREADY", s_TREADY, 1'b0);
            @(posedge clk_200MHz);
            #1;
        end
        peripheral_reset = 1'b0;
        expq.delete();
        m_ok = 0; m_drop = 0; m_err = 0;
        check("rst_m_TVALID", m_TVALID, 1'b0);
        check("rst_m_TLAST", m_TLAST, 1'b0);
        check("rst_m_TDATA", m_TDATA, 32'd0);
        check("rst_m_tx_uid", m_tx_uid, 8'd0);
        check("rst_ok_cnt", msg_ok_cnt, 16'd0);
        check("rst_drop_cnt", msg_drop_cnt, 16'd0);
        check("rst_err_cnt", msg_err_cnt, 16'd0);
        check("rst_busy", busy, 1'b0);
    endtask

    initial begin
        int w0, rx, n;
        logic [31:0] hdr;

        do_reset(3);

        // Nominal 216-word message with steady consumer.
        rmode = 0; gaps = 0; lat_chk = 1;
        w0 = out_words;
        send_msg(32'h02010000, 216, 1, -1);
        wait_idle();
        check_counts("nominal");
        check("nominal_words", out_words - w0, 216);
        check("nominal_ok_lit", msg_ok_cnt, 16'd1);
        check("nominal_uid_lit", m_tx_uid, 8'h01);

        // Address filtering: dropped, then broadcast forwarded.
        w0 = out_words;
        send_msg(32'h05010000, 10, 0, -1);
        wait_idle();
        check("drop_no_output", out_words - w0, 0);
        check("drop_cnt_lit", msg_drop_cnt, 16'd1);
        check("drop_keeps_uid", m_tx_uid, 8'h01);
        send_msg(32'hFF030000, 4, 0, -1);
        wait_idle();
        check_counts("bcast");
        check("bcast_uid_lit", m_tx_uid, 8'h03);

        // Alternating backpressure over a 16-word message.
        rmode = 1;
        w0 = out_words;
        send_msg(32'h02040000, 16, 0, -1);
        wait_idle();
        check("bp_words", out_words - w0, 16);
        check_counts("bp");
        rmode = 0;

        // Overlength: truncated at MAXW, rest discarded, next header accepted.
        w0 = out_words;
        send_msg(32'h02050000, MAXW + 4, 0, -1);
        wait_idle();
        check("trunc_words", out_words - w0, MAXW);
        check("trunc_err_lit", msg_err_cnt, 16'd1);
        check_counts("trunc");
        send_msg(32'h02060000, MAXW, 0, -1);
        wait_idle();
        check("exact_max_no_err", msg_err_cnt, 16'd1);
        check_counts("exact_max");

        // Header-only message, then a normal one.
        w0 = out_words;
        send_msg(32'h02010000, 0, 0, -1);
        wait_idle();
        check("hdr_only_err_lit", msg_err_cnt, 16'd2);
        check("hdr_only_no_output", out_words - w0, 0);
        send_msg(32'h02080000, 5, 0, -1);
        wait_idle();
        check_counts("after_hdr_only");

        // Randomized messages with random gaps and random consumer ready.
        rmode = 2; gaps = 1;
        for (int k = 0; k < 80; k++) begin
            rx = $urandom_range(0, 3);
            case (rx)
                0: hdr[31:24] = LOCAL;
                1: hdr[31:24] = BCAST;
                2: hdr[31:24] = 8'h05;
                default: hdr[31:24] = 8'($urandom_range(3, 254));
            endcase
            hdr[23:0] = 24'($urandom);
            if ($urandom_range(0, 15) == 0) n = $urandom_range(MAXW - 1, MAXW + 2);
            else n = $urandom_range(0, 20);
            send_msg(hdr, n, 0, -1);
        end
        wait_idle();
        check_counts("random");

        // Reset in the middle of a message.
        rmode = 0; gaps = 0;
        send_msg(32'h02090000, 20, 0, 5);
        do_reset(1);
        send_msg(32'h02070000, 3, 0, -1);
        wait_idle();
        check("post_rst_uid_lit", m_tx_uid, 8'h07);
        check("post_rst_ok_lit", msg_ok_cnt, 16'd1);
        check_counts("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
